// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner and the matrix keypad / its consumer.
interface keypad_scanner_if;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows_n,
        output cols_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows_n,
        input  cols_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad one column at a time and reports a debounced
// single key press as a one-cycle strobe plus a held level.
module keypad_scanner #(
    parameter int SCAN_CYCLES      = 25000,
    parameter int DEBOUNCE_SAMPLES = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    keypad_scanner_if.master bus
);
    localparam int TW = $clog2(SCAN_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        r_state;
    logic [3:0]    r_sync1;
    logic [3:0]    r_rs;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_colIdx;
    logic [1:0]    r_candRow;
    logic [CW-1:0] r_debCnt;
    logic [CW-1:0] r_relCnt;
    logic [3:0]    r_colsN;
    logic [3:0]    r_keyCode;
    logic          r_keyValid;
    logic          r_keyHeld;

    logic          w_tick;
    logic [2:0]    w_numLow;
    logic [1:0]    w_lowRow;
    logic          w_none;
    logic          w_single;
    logic          w_candMatch;
    logic [1:0]    w_nextCol;
    logic [3:0]    w_nextColsN;

    assign bus.cols_n    = r_colsN;
    assign bus.key_code  = r_keyCode;
    assign bus.key_valid = r_keyValid;
    assign bus.key_held  = r_keyHeld;

    // Rows are asynchronous to clk; two flops before anything looks at them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= bus.rows_n;
            r_rs    <= r_sync1;
        end
    end

    assign w_tick = (r_timer == TIMER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_comb begin
        w_numLow = 3'd0;
        w_lowRow = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!r_rs[r]) begin
                w_numLow = w_numLow + 3'd1;
                w_lowRow = 2'(r);
            end
        end
    end

    assign w_none      = (w_numLow == 3'd0);
    assign w_single    = (w_numLow == 3'd1);
    assign w_candMatch = w_single && (w_lowRow == r_candRow);
    assign w_nextCol   = r_colIdx + 2'd1;
    assign w_nextColsN = ~(4'b0001 << w_nextCol);

    // The column only moves on when the FSM gives up on or releases a key;
    // both counters stop at their last value so they never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= SCAN;
            r_colIdx   <= 2'd0;
            r_colsN    <= 4'b1110;
            r_candRow  <= 2'd0;
            r_debCnt   <= '0;
            r_relCnt   <= '0;
            r_keyCode  <= 4'd0;
            r_keyValid <= 1'b0;
            r_keyHeld  <= 1'b0;
        end else begin
            r_keyValid <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    SCAN: begin
                        if (w_single) begin
                            r_candRow <= w_lowRow;
                            r_debCnt  <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_colIdx <= w_nextCol;
                            r_colsN  <= w_nextColsN;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_candMatch) begin
                            if (r_debCnt == CNT_LAST) begin
                                r_keyCode  <= {r_candRow, r_colIdx};
                                r_keyValid <= 1'b1;
                                r_keyHeld  <= 1'b1;
                                r_relCnt   <= '0;
                                r_state    <= HELD;
                            end else begin
                                r_debCnt <= r_debCnt + CW'(1);
                            end
                        end else begin
                            r_colIdx <= w_nextCol;
                            r_colsN  <= w_nextColsN;
                            r_state  <= SCAN;
                        end
                    end
                    HELD: begin
                        if (w_none) begin
                            if (r_relCnt == CNT_LAST) begin
                                r_keyHeld <= 1'b0;
                                r_colIdx  <= w_nextCol;
                                r_colsN   <= w_nextColsN;
                                r_state   <= SCAN;
                            end else begin
                                r_relCnt <= r_relCnt + CW'(1);
                            end
                        end else begin
                            r_relCnt <= '0;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model, a streak-based reference
// model compared every cycle, directed scenarios and randomized presses.
module tb_keypad_scanner;
    localparam int SC = 4;
    localparam int DS = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] pressed = 16'h0000;

    int checks     = 0;
    int errors     = 0;
    int validCount = 0;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_CYCLES(SC),
        .DEBOUNCE_SAMPLES(DS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(kif.master)
    );

    always #5 clk = ~clk;

    // A key at (row, col) shorts its row low while its column is driven low.
    always_comb begin
        kif.rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.cols_n[c]) kif.rows_n[r] = 1'b0;
            end
        end
    end

    logic [3:0] mDelay[2] = '{4'hF, 4'hF};
    logic [3:0] mSample;
    int         mTimer   = 0;
    int         mCol     = 0;
    int         mCandRow = 0;
    int         mStreak  = 0;
    int         mRel     = 0;
    int         nLow;
    int         lowRow;
    logic [3:0] mCode    = 4'd0;
    logic       mValid   = 1'b0;
    logic       mHeld    = 1'b0;
    logic [3:0] expCols;

    // Reference: a key is accepted after DS+1 consecutive single-row samples of
    // the same row in a frozen column, released after DS consecutive empty ones.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mDelay[0] = 4'hF;
            mDelay[1] = 4'hF;
            mTimer    = 0;
            mCol      = 0;
            mCandRow  = 0;
            mStreak   = 0;
            mRel      = 0;
            mCode     = 4'd0;
            mValid    = 1'b0;
            mHeld     = 1'b0;
        end else begin
            mSample   = mDelay[1];
            mDelay[1] = mDelay[0];
            mDelay[0] = kif.rows_n;
            mValid    = 1'b0;
            if (mTimer == SC - 1) begin
                nLow   = 0;
                lowRow = 0;
                for (int r = 0; r < 4; r++) begin
                    if (!mSample[r]) begin
                        nLow++;
                        lowRow = r;
                    end
                end
                if (mHeld) begin
                    if (nLow == 0) begin
                        mRel++;
                        if (mRel == DS) begin
                            mHeld = 1'b0;
                            mRel  = 0;
                            mCol  = (mCol + 1) % 4;
                        end
                    end else begin
                        mRel = 0;
                    end
                end else if (mStreak == 0) begin
                    if (nLow == 1) begin
                        mCandRow = lowRow;
                        mStreak  = 1;
                    end else begin
                        mCol = (mCol + 1) % 4;
                    end
                end else if (nLow == 1 && lowRow == mCandRow) begin
                    mStreak++;
                    if (mStreak == DS + 1) begin
                        mCode   = 4'(mCandRow * 4 + mCol);
                        mValid  = 1'b1;
                        mHeld   = 1'b1;
                        mStreak = 0;
                        mRel    = 0;
                    end
                end else begin
                    mStreak = 0;
                    mCol    = (mCol + 1) % 4;
                end
            end
            mTimer = (mTimer + 1) % SC;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        expCols       = 4'hF;
        expCols[mCol] = 1'b0;
        checkOutput("model_cols_n", 32'(kif.cols_n), 32'(expCols));
        checkOutput("model_key_code", 32'(kif.key_code), 32'(mCode));
        checkOutput("model_key_valid", 32'(kif.key_valid), 32'(mValid));
        checkOutput("model_key_held", 32'(kif.key_held), 32'(mHeld));
        if (kif.key_valid === 1'b1) validCount++;
    end

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        pressed = keys;
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (kif.key_valid === 1'b1) break;
            @(negedge clk);
            #1;
        end
        checkOutput(name, 32'(kif.key_valid), 32'd1);
    endtask

    task automatic waitHeldLow(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (kif.key_held === 1'b0) break;
            @(negedge clk);
            #1;
        end
        checkOutput(name, 32'(kif.key_held), 32'd0);
    endtask

    logic [3:0]  idleSeq[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int          vStart;
    int          sel;
    logic [15:0] keys;

    initial begin
        $display("[TB] keypad_scanner bench, SCAN_CYCLES=%0d DEBOUNCE_SAMPLES=%0d", SC, DS);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_cols_n", 32'(kif.cols_n), 32'h0000_000E);
        checkOutput("reset_key_held", 32'(kif.key_held), 32'd0);
        checkOutput("reset_key_code", 32'(kif.key_code), 32'd0);
        reset_n = 1'b1;

        // Idle scan walks the columns every SC clocks.
        for (int i = 0; i < 4; i++) begin
            repeat (SC) @(negedge clk);
            #1;
            checkOutput("idle_cols_seq", 32'(kif.cols_n), 32'(idleSeq[i]));
        end
        checkOutput("idle_no_valid", 32'(validCount), 32'd0);

        // Clean press of row 2 / column 1.
        vStart = validCount;
        pressed = 16'(1 << 9);
        waitValid("press_valid", 200);
        checkOutput("press_code", 32'(kif.key_code), 32'h9);
        #10;
        checkOutput("press_held", 32'(kif.key_held), 32'd1);
        checkOutput("press_cols_frozen", 32'(kif.cols_n), 32'hD);
        applyStimulus(16'(1 << 9), 40);
        checkOutput("press_one_strobe", 32'(validCount - vStart), 32'd1);

        // Release resumes scanning at column 2.
        pressed = 16'h0000;
        waitHeldLow("release_held_low", 100);
        checkOutput("release_next_col", 32'(kif.cols_n), 32'hB);
        applyStimulus(16'h0000, 20);

        // Bouncing contact at row 0 / column 3 never survives debounce.
        vStart = validCount;
        for (int i = 0; i < 30; i++) applyStimulus(pressed ^ 16'(1 << 3), SC);
        checkOutput("bounce_no_valid", 32'(validCount - vStart), 32'd0);
        applyStimulus(16'h0000, 20);

        // Two rows low in column 0 is ignored.
        vStart = validCount;
        applyStimulus(16'h0011, 100);
        checkOutput("multi_no_valid", 32'(validCount - vStart), 32'd0);
        applyStimulus(16'h0000, 20);

        // One-tick release while held produces no second strobe.
        pressed = 16'(1 << 14);
        waitValid("repress_first_valid", 200);
        checkOutput("repress_code", 32'(kif.key_code), 32'hE);
        vStart = validCount;
        applyStimulus(16'(1 << 14), 8);
        applyStimulus(16'h0000, SC);
        applyStimulus(16'(1 << 14), 60);
        checkOutput("repress_no_second", 32'(validCount - vStart), 32'd0);
        checkOutput("repress_still_held", 32'(kif.key_held), 32'd1);
        pressed = 16'h0000;
        waitHeldLow("repress_release", 100);
        applyStimulus(16'h0000, 20);

        // Reset while key 4'hF is held, then re-detection after reset.
        pressed = 16'(1 << 15);
        waitValid("midreset_first_valid", 200);
        applyStimulus(16'(1 << 15), 8);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_cols_n", 32'(kif.cols_n), 32'hE);
        checkOutput("midreset_code", 32'(kif.key_code), 32'd0);
        checkOutput("midreset_valid", 32'(kif.key_valid), 32'd0);
        checkOutput("midreset_held", 32'(kif.key_held), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        waitValid("midreset_revalid", 200);
        checkOutput("midreset_recode", 32'(kif.key_code), 32'hF);
        pressed = 16'h0000;
        waitHeldLow("midreset_release", 100);
        applyStimulus(16'h0000, 20);

        // Randomized presses, checked cycle by cycle against the model.
        for (int i = 0; i < 80; i++) begin
            sel  = int'($urandom_range(0, 3));
            keys = 16'h0000;
            if (sel == 1 || sel == 2) begin
                keys[$urandom_range(0, 15)] = 1'b1;
            end else if (sel == 3) begin
                keys[$urandom_range(0, 15)] = 1'b1;
                keys[$urandom_range(0, 15)] = 1'b1;
            end
            applyStimulus(keys, int'($urandom_range(2, 60)));
        end
        applyStimulus(16'h0000, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
